// File: rtl/sdio_dispatch_pkg.sv
// Shared types and helpers for the SDIO command dispatcher.
package sdio_dispatch_pkg;

  localparam int CMD_W  = 6;
  localparam int ARG_W  = 32;
  localparam int PORT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Handler port is the upper two bits of the command index.
  function automatic logic [PORT_W-1:0] cmd_to_port(input logic [CMD_W-1:0] cmd);
    return cmd[5:4];
  endfunction

endpackage

// File: rtl/sdio_timeout.sv
// 16-bit handler response timer: cleared on issue, counts while enabled, sticks at its last value.
module sdio_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign expired = (r_cnt == LAST);

endmodule

// File: rtl/sdio_dispatch.sv
// Routes decoded SDIO commands to one of four handlers and returns the answer or a timeout value.
// Optional statistics counters (drop_cnt, timeout_cnt) are built when SDIO_DISPATCH_STATS_EN is defined.
module sdio_dispatch
  import sdio_dispatch_pkg::*;
#(
  parameter int               NUM_PORTS      = 4,
  parameter int               TIMEOUT_CYCLES = 1024,
  parameter logic [ARG_W-1:0] TIMEOUT_ARG    = 32'hFFFF_FFFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic [CMD_W-1:0]           req_cmd,
  input  logic [ARG_W-1:0]           req_arg,
  output logic                       resp_valid,
  output logic [ARG_W-1:0]           resp_arg,
  output logic                       busy,
  output logic [NUM_PORTS-1:0]       h_req_valid,
  output logic [CMD_W-1:0]           h_req_cmd,
  output logic [ARG_W-1:0]           h_req_arg,
  input  logic [NUM_PORTS-1:0]       h_resp_valid,
  input  logic [NUM_PORTS*ARG_W-1:0] h_resp_arg
`ifdef SDIO_DISPATCH_STATS_EN
  ,
  output logic [15:0]                drop_cnt,
  output logic [15:0]                timeout_cnt
`endif
);

  // All four valid signals are single-cycle strobes with no back-pressure;
  // a request is accepted only in IDLE and anything arriving later is dropped.
  state_t           r_state;
  state_t           w_next;
  logic [CMD_W-1:0] r_cmd;
  logic [ARG_W-1:0] r_arg;
  logic [ARG_W-1:0] r_resp_arg;
  logic [PORT_W-1:0] w_port;
  logic             w_hit;
  logic             w_expired;
  logic             w_timeout;
  logic             w_clear;
  logic             w_enable;

  assign w_port    = cmd_to_port(r_cmd);
  assign w_hit     = h_resp_valid[w_port];
  assign w_timeout = (r_state == WAIT) && w_expired && !w_hit;

  sdio_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_clear),
    .enable (w_enable),
    .expired(w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (req_valid) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (w_hit || w_expired) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    h_req_valid = '0;
    if (r_state == ISSUE) h_req_valid[w_port] = 1'b1;
    resp_valid = (r_state == RESP);
    busy       = (r_state != IDLE);
    w_clear    = (r_state == ISSUE);
    w_enable   = (r_state == WAIT);
  end

  // A handler answer on the final timeout cycle takes priority over the timeout value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd      <= '0;
      r_arg      <= '0;
      r_resp_arg <= '0;
    end else begin
      if ((r_state == IDLE) && req_valid) begin
        r_cmd <= req_cmd;
        r_arg <= req_arg;
      end
      if (r_state == WAIT) begin
        if (w_hit) r_resp_arg <= h_resp_arg[ARG_W*int'(w_port) +: ARG_W];
        else if (w_expired) r_resp_arg <= TIMEOUT_ARG;
      end
    end
  end

  assign h_req_cmd = r_cmd;
  assign h_req_arg = r_arg;
  assign resp_arg  = r_resp_arg;

`ifdef SDIO_DISPATCH_STATS_EN
  logic [15:0] r_drop_cnt;
  logic [15:0] r_timeout_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt    <= '0;
      r_timeout_cnt <= '0;
    end else begin
      if (req_valid && (r_state != IDLE) && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_timeout && (r_timeout_cnt != 16'hFFFF))
        r_timeout_cnt <= r_timeout_cnt + 16'd1;
    end
  end

  assign drop_cnt    = r_drop_cnt;
  assign timeout_cnt = r_timeout_cnt;
`endif

endmodule

// File: tb/tb_sdio_dispatch.sv
// Scoreboard bench for sdio_dispatch: driver tasks push expectations, a negedge monitor pops and compares.
// Define SDIO_DISPATCH_STATS_EN to also check the statistics counters.
module tb_sdio_dispatch;

  localparam int          TO     = 16;
  localparam logic [31:0] TO_ARG = 32'hFFFF_FFFF;

  typedef struct {
    logic [3:0]  hv;
    logic [5:0]  cmd;
    logic [31:0] arg;
    int          cyc;
  } hreq_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic [5:0]   req_cmd = '0;
  logic [31:0]  req_arg = '0;
  logic         resp_valid;
  logic [31:0]  resp_arg;
  logic         busy;
  logic [3:0]   h_req_valid;
  logic [5:0]   h_req_cmd;
  logic [31:0]  h_req_arg;
  logic [3:0]   h_resp_valid = '0;
  logic [127:0] h_resp_arg = '0;
`ifdef SDIO_DISPATCH_STATS_EN
  logic [15:0]  drop_cnt;
  logic [15:0]  timeout_cnt;
`endif

  hreq_t       hreq_q[$];
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  hreq_t       mon_h;
  int          mon_c;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int bz_lo = 1, bz_hi = 0, exp_drop = 0, exp_to = 0;

  sdio_dispatch #(
    .NUM_PORTS     (4),
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_ARG   (TO_ARG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_cmd     (req_cmd),
    .req_arg     (req_arg),
    .resp_valid  (resp_valid),
    .resp_arg    (resp_arg),
    .busy        (busy),
    .h_req_valid (h_req_valid),
    .h_req_cmd   (h_req_cmd),
    .h_req_arg   (h_req_arg),
    .h_resp_valid(h_resp_valid),
    .h_resp_arg  (h_resp_arg)
`ifdef SDIO_DISPATCH_STATS_EN
    ,
    .drop_cnt    (drop_cnt),
    .timeout_cnt (timeout_cnt)
`endif
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_stats();
`ifdef SDIO_DISPATCH_STATS_EN
    check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    check("timeout_cnt", 32'(timeout_cnt), 32'(exp_to));
`endif
  endtask

  // One transaction. delay = cycles from the h_req_valid strobe to the handler answer, 0 = never answers.
  task automatic run_txn(input logic [5:0] cmd, input logic [31:0] arg, input int delay,
                         input logic [31:0] val, input int noise_port, input bit drop);
    int c0, p, rc, kresp, knoise, kdrop, last;
    hreq_t h;
    p = int'(cmd[5:4]);
    @(posedge clk); #1;
    c0 = cyc;
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_arg   = arg;
    h.hv  = 4'b0001 << p;
    h.cmd = cmd;
    h.arg = arg;
    h.cyc = c0 + 1;
    hreq_q.push_back(h);
    kresp = (delay > 0) ? c0 + 1 + delay : -1;
    if ((delay > 0) && (delay <= TO)) begin
      rc = kresp + 1;
      exp_q.push_back(val);
    end else begin
      rc = c0 + TO + 2;
      exp_q.push_back(TO_ARG);
      exp_to++;
    end
    exp_cyc_q.push_back(rc);
    bz_lo  = c0 + 1;
    bz_hi  = rc;
    knoise = (noise_port >= 0) ? c0 + 2 + int'($urandom_range(0, rc - c0 - 3)) : -1;
    kdrop  = drop ? c0 + 1 + int'($urandom_range(0, rc - c0 - 1)) : -1;
    if (drop) exp_drop++;
    last = ((kresp > rc) ? kresp : rc) + 1;
    for (int t = c0 + 1; t <= last; t++) begin
      @(posedge clk); #1;
      req_valid    = (t == kdrop);
      req_cmd      = ~cmd;
      req_arg      = ~arg;
      h_resp_valid = '0;
      for (int i = 0; i < 4; i++) h_resp_arg[32*i +: 32] = $urandom;
      if (t == kresp) begin
        h_resp_valid[p]        = 1'b1;
        h_resp_arg[32*p +: 32] = val;
      end
      if (t == knoise) h_resp_valid[noise_port] = 1'b1;
    end
    @(posedge clk); #1;
    req_valid    = 1'b0;
    h_resp_valid = '0;
    check("hold_cmd", 32'(h_req_cmd), 32'(cmd));
    check("hold_arg", h_req_arg, arg);
  endtask

  // Reset lands mid-WAIT; a late handler answer afterwards must not produce a response.
  task automatic run_reset_txn();
    int c0;
    hreq_t h;
    @(posedge clk); #1;
    c0 = cyc;
    req_valid = 1'b1;
    req_cmd   = 6'h21;
    req_arg   = 32'h1234_5678;
    h.hv  = 4'b0100;
    h.cmd = 6'h21;
    h.arg = 32'h1234_5678;
    h.cyc = c0 + 1;
    hreq_q.push_back(h);
    bz_lo = c0 + 1;
    bz_hi = c0 + 3;
    repeat (4) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    #2;
    rst      = 1'b1;
    exp_drop = 0;
    exp_to   = 0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_h_req_valid", 32'(h_req_valid), 32'd0);
    check("rst_h_req_cmd", 32'(h_req_cmd), 32'd0);
    check("rst_h_req_arg", h_req_arg, 32'd0);
    check("rst_resp_arg", resp_arg, 32'd0);
    check_stats();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    h_resp_valid          = 4'b0100;
    h_resp_arg[64 +: 32]  = 32'h0000_CAFE;
    @(posedge clk); #1;
    h_resp_valid = '0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", 32'(busy), 32'((cyc >= bz_lo) && (cyc <= bz_hi)));
      if (h_req_valid != 4'b0000) begin
        if (hreq_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL h_req_unexpected: got %b expected none (cycle %0d)", h_req_valid, cyc);
        end else begin
          mon_h = hreq_q.pop_front();
          check("h_req_valid", 32'(h_req_valid), 32'(mon_h.hv));
          check("h_req_cmd", 32'(h_req_cmd), 32'(mon_h.cmd));
          check("h_req_arg", h_req_arg, mon_h.arg);
          check("h_req_cycle", 32'(cyc), 32'(mon_h.cyc));
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL resp_unexpected: got arg %h expected none (cycle %0d)", resp_arg, cyc);
        end else begin
          mon_c = exp_cyc_q.pop_front();
          check("resp_arg", resp_arg, exp_q.pop_front());
          check("resp_cycle", 32'(cyc), 32'(mon_c));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int dly, np, p;
    logic [5:0] c;
    #1;
    check("init_busy", 32'(busy), 32'd0);
    check("init_resp_valid", 32'(resp_valid), 32'd0);
    check("init_h_req_valid", 32'(h_req_valid), 32'd0);
    check("init_resp_arg", resp_arg, 32'd0);
    check("init_h_req_cmd", 32'(h_req_cmd), 32'd0);
    check("init_h_req_arg", h_req_arg, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run_txn(6'h3F, 32'hF000_0F0F, 5, 32'hF00F_F00F, -1, 1'b0);
    run_txn(6'h05, 32'h0000_0005, 0, 32'h0, -1, 1'b0);
    check_stats();
    run_txn(6'h12, 32'hA5A5_0001, 6, 32'h1111_2222, -1, 1'b1);
    check_stats();
    run_txn(6'h20, 32'h0000_0020, 8, 32'h2222_2222, 1, 1'b0);
    run_txn(6'h31, 32'h0BAD_F00D, TO, 32'h5EED_5EED, -1, 1'b0);
    run_txn(6'h0A, 32'h0000_00AA, 1, 32'h0000_0001, -1, 1'b0);
    run_txn(6'h2B, 32'h0000_002B, TO + 1, 32'h7777_7777, -1, 1'b0);
    check_stats();

    for (int n = 0; n < 40; n++) begin
      c   = 6'($urandom_range(0, 63));
      p   = int'(c[5:4]);
      dly = int'($urandom_range(0, TO + 3));
      np  = ($urandom_range(0, 1) == 1) ? (p + 1 + int'($urandom_range(0, 2))) % 4 : -1;
      run_txn(c, $urandom, dly, $urandom, np, 1'($urandom_range(0, 1)));
    end
    check_stats();

    run_reset_txn();
    run_txn(6'h33, 32'h3333_0000, 3, 32'h3333_AAAA, -1, 1'b0);
    check_stats();

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("hreq_q_empty", 32'(hreq_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdio_dispatch.md
SDIO_DISPATCH -- requirements
Module: sdio_dispatch

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of command handler ports (fixed at 4 in this revision).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, handler response timeout in clk cycles (2..65535).
REQ-003 SHALL have parameter TIMEOUT_ARG, default 32'hFFFF_FFFF, resp_arg value returned on timeout.
REQ-004 SHALL have ports, one per line as: name  direction  width  meaning.
- clk  in  1  single clock; all logic is synchronous to its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  one-cycle pulse from the SDIO core: command decoded.
- req_cmd  in  6  command index.
- req_arg  in  32  command argument.
- resp_valid  out  1  one-cycle pulse to the SDIO core: response ready.
- resp_arg  out  32  response argument.
- busy  out  1  high while a command is in flight.
- h_req_valid  out  NUM_PORTS  one-hot, one-cycle request strobe per handler.
- h_req_cmd  out  6  latched command, shared by all handlers.
- h_req_arg  out  32  latched argument, shared by all handlers.
- h_resp_valid  in  NUM_PORTS  per-handler response strobe.
- h_resp_arg  in  NUM_PORTS*32  per-handler response argument; port i occupies bits [32*i+31:32*i].

Function
REQ-005 SHALL route each command to port = req_cmd[5:4], computed by the package function cmd_to_port.
REQ-006 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-007 IDLE: on req_valid, SHALL latch req_cmd and req_arg into h_req_cmd and h_req_arg and go to ISSUE.
REQ-008 ISSUE: SHALL assert h_req_valid[port] for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-009 WAIT: on h_resp_valid[port], SHALL latch h_resp_arg of that port into resp_arg and go to RESP.
REQ-010 WAIT: h_resp_valid from any non-selected port SHALL be ignored.
REQ-011 WAIT: when the counter reaches TIMEOUT_CYCLES-1 with no response, SHALL load TIMEOUT_ARG into resp_arg and go to RESP.
REQ-012 If a response and the timeout occur in the same cycle, the response SHALL win.
REQ-013 RESP: SHALL assert resp_valid for exactly one cycle and return to IDLE.
REQ-014 Latency: req_valid at cycle 0 -> h_req_valid at cycle 1; h_resp_valid at cycle k -> resp_valid at cycle k+1.
REQ-015 busy SHALL be high in ISSUE, WAIT and RESP, and low in IDLE.
REQ-016 A req_valid received in ISSUE, WAIT or RESP SHALL be dropped; no queueing.
REQ-017 h_req_cmd and h_req_arg SHALL hold their value until the next accepted request.
REQ-018 The timeout counter SHALL be 16 bits wide and SHALL not wrap within a transaction.

Reset
REQ-019 On rst, the FSM SHALL go to IDLE immediately, regardless of clk.
REQ-020 On rst, resp_valid, h_req_valid and busy SHALL be 0; resp_arg, h_req_cmd and h_req_arg SHALL be 0; the counter SHALL be 0.
REQ-021 A reset during WAIT SHALL abort the transaction with no resp_valid issued.
REQ-022 A late h_resp_valid arriving after reset SHALL be ignored.

Configuration
REQ-023 With SDIO_DISPATCH_STATS_EN defined, the block SHALL add 16-bit outputs drop_cnt and timeout_cnt.
REQ-024 drop_cnt SHALL count requests dropped per REQ-016; timeout_cnt SHALL count timeouts per REQ-011.
REQ-025 Both counters SHALL saturate at 16'hFFFF and SHALL reset to 0.
REQ-026 Without SDIO_DISPATCH_STATS_EN, these ports and their counter logic SHALL be absent.

Structure
REQ-027 Package sdio_dispatch_pkg SHALL hold the FSM state enum, the cmd_to_port function, and the constants CMD_W=6 and ARG_W=32.
REQ-028 The timeout counter SHALL be the sub-module sdio_timeout, with inputs clear and enable and output expired.

Verification
REQ-029 Scenario: cmd 0x3F, arg 0xF0000F0F; port 3 answers 0xF00FF00F after 5 cycles -> h_req_valid=4'b1000 at cycle 1; resp_valid at cycle 7 with resp_arg=0xF00FF00F.
REQ-030 Scenario: cmd 0x05 with no handler answer -> resp_valid exactly TIMEOUT_CYCLES+2 cycles after req_valid, resp_arg=0xFFFFFFFF; timeout_cnt=1 when the macro is defined.
REQ-031 Scenario: second req_valid during WAIT -> exactly one resp_valid; h_req_arg unchanged; drop_cnt=1.
REQ-032 Scenario: port 1 pulses h_resp_valid while cmd 0x20 (port 2) is pending -> the pulse is ignored; only the port 2 answer is returned.
REQ-033 Scenario: rst asserted mid-WAIT -> busy=0 immediately; a later h_resp_valid produces no resp_valid.
REQ-034 Scenario: response on the final timeout cycle -> resp_arg equals the handler value, not TIMEOUT_ARG.
